// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between core (C) and loader (D) ports.
// Grants are combinational in the request cycle; read data returns one cycle later; an ungranted requester holds req.
module dmem_port_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_lock,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);
    localparam logic LOCK_OK = (MAX_BURST > 1);

    typedef enum logic {ST_ARB, ST_LOCK} state_t;

    state_t           state_q, state_d;
    logic             last_d_q, last_d_d;   // 1: D was the most recent winner
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             c_rvalid_q, d_rvalid_q;
    logic             c_win, d_win;

    always_comb begin
        c_win = 1'b0;
        d_win = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_ARB: begin
                    if (c_req && d_req) begin
                        c_win = last_d_q;
                        d_win = ~last_d_q;
                    end else begin
                        c_win = c_req;
                        d_win = d_req;
                    end
                end
                ST_LOCK: begin
                    d_win = d_req;
                    c_win = ~d_req & c_req;
                end
                default: begin
                    c_win = 1'b0;
                    d_win = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        last_d_d    = last_d_q;
        if (c_win) last_d_d = 1'b0;
        if (d_win) last_d_d = 1'b1;
        case (state_q)
            ST_ARB: begin
                // With a single-grant burst the lock would add nothing, so stay in ARB
                if (d_win && d_lock && LOCK_OK) begin
                    state_d     = ST_LOCK;
                    burst_cnt_d = CNT_W'(1);
                end
            end
            ST_LOCK: begin
                if (d_win) begin
                    if (!d_lock || burst_cnt_q == LAST_CNT) begin
                        state_d     = ST_ARB;
                        burst_cnt_d = '0;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end else begin
                    state_d     = ST_ARB;
                    burst_cnt_d = '0;
                    last_d_d    = ~c_win;
                end
            end
            default: begin
                state_d     = ST_ARB;
                burst_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_ARB;
            last_d_q    <= 1'b1;
            burst_cnt_q <= '0;
            c_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            burst_cnt_q <= burst_cnt_d;
            c_rvalid_q  <= c_win & ~c_we;
            d_rvalid_q  <= d_win & ~d_we;
        end
    end

    assign c_gnt     = c_win;
    assign d_gnt     = d_win;
    assign mem_rd_en = (c_win & ~c_we) | (d_win & ~d_we);
    assign mem_wr_en = (c_win & c_we) | (d_win & d_we);
    assign mem_addr  = c_win ? c_addr  : (d_win ? d_addr  : '0);
    assign mem_wdata = c_win ? c_wdata : (d_win ? d_wdata : '0);

    assign c_rvalid  = c_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign c_rdata   = c_rvalid_q ? mem_rdata : '0;
    assign d_rdata   = d_rvalid_q ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a synchronous memory model and a read-return scoreboard.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req, c_we, c_gnt, c_rvalid;
    logic [7:0]  c_addr;
    logic [15:0] c_wdata, c_rdata;
    logic        d_req, d_we, d_lock, d_gnt, d_rvalid;
    logic [7:0]  d_addr;
    logic [15:0] d_wdata, d_rdata;
    logic        mem_rd_en, mem_wr_en;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        cv;
        logic        dv;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mem [256];
    logic [15:0] ref_mem [256];

    dmem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int i);
        logic [15:0] v;
        v = 16'(i * 16'h0111) ^ 16'h5A00;
        if (i == 5) v = 16'h1234;
        return v;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            mem_rdata <= '0;
        end else begin
            if (mem_wr_en) mem[mem_addr] <= mem_wdata;
            if (mem_rd_en) mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag,
                        input logic cr, input logic cw, input logic [7:0] ca, input logic [15:0] cd,
                        input logic dr, input logic dw, input logic dl, input logic [7:0] da,
                        input logic [15:0] dd, input logic ec, input logic ed);
        exp_t e, n;
        @(negedge clk);
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        d_req = dr; d_we = dw; d_lock = dl; d_addr = da; d_wdata = dd;
        #1;
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        chk({tag, " c_rvalid"}, 32'(c_rvalid), 32'(e.cv));
        chk({tag, " d_rvalid"}, 32'(d_rvalid), 32'(e.dv));
        chk({tag, " c_rdata"},  32'(c_rdata),  e.cv ? 32'(e.data) : 32'd0);
        chk({tag, " d_rdata"},  32'(d_rdata),  e.dv ? 32'(e.data) : 32'd0);
        chk({tag, " c_gnt"},    32'(c_gnt),    32'(ec));
        chk({tag, " d_gnt"},    32'(d_gnt),    32'(ed));
        chk({tag, " mem_rd_en"}, 32'(mem_rd_en), 32'((ec & ~cw) | (ed & ~dw)));
        chk({tag, " mem_wr_en"}, 32'(mem_wr_en), 32'((ec & cw) | (ed & dw)));
        chk({tag, " mem_addr"},  32'(mem_addr),  ec ? 32'(ca) : (ed ? 32'(da) : 32'd0));
        chk({tag, " mem_wdata"}, 32'(mem_wdata), ec ? 32'(cd) : (ed ? 32'(dd) : 32'd0));
        n.cv   = ec & ~cw;
        n.dv   = ed & ~dw;
        n.data = ec ? ref_mem[ca] : (ed ? ref_mem[da] : 16'd0);
        if (ec && cw) ref_mem[ca] = cd;
        if (ed && dw) ref_mem[da] = dd;
        sb.push_back(n);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 8'd0, 16'd0, 0, 0, 0, 8'd0, 16'd0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        c_req = 1; c_we = 0; c_addr = 8'd9; c_wdata = 16'hBEEF;
        d_req = 1; d_we = 1; d_lock = 1; d_addr = 8'd9; d_wdata = 16'hCAFE;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        @(posedge clk);
        @(negedge clk);
        chk("reset c_gnt", 32'(c_gnt), 32'd0);
        chk("reset d_gnt", 32'(d_gnt), 32'd0);
        chk("reset mem_wr_en", 32'(mem_wr_en), 32'd0);
        chk("reset mem_addr", 32'(mem_addr), 32'd0);
        chk("reset c_rvalid", 32'(c_rvalid), 32'd0);
        reset = 1'b0;
        c_req = 0; d_req = 0; d_lock = 0;

        // Conflicts from reset alternate starting with C
        step("rr0", 1, 0, 8'd10, 16'd0, 1, 0, 0, 8'd20, 16'd0, 1, 0);
        step("rr1", 1, 0, 8'd11, 16'd0, 1, 0, 0, 8'd20, 16'd0, 0, 1);
        step("rr2", 1, 0, 8'd12, 16'd0, 1, 0, 0, 8'd21, 16'd0, 1, 0);
        step("rr3", 1, 0, 8'd13, 16'd0, 1, 0, 0, 8'd21, 16'd0, 0, 1);
        idle("rr_flush");

        step("crd5", 1, 0, 8'd5, 16'd0, 0, 0, 0, 8'd0, 16'd0, 1, 0);
        idle("crd5_ret");

        // Lock burst of MAX_BURST D grants, then C, then D
        step("bst0", 1, 0, 8'd40, 16'd0, 1, 0, 1, 8'd30, 16'd0, 0, 1);
        step("bst1", 1, 0, 8'd40, 16'd0, 1, 0, 1, 8'd31, 16'd0, 0, 1);
        step("bst2", 1, 0, 8'd40, 16'd0, 1, 0, 1, 8'd32, 16'd0, 0, 1);
        step("bst3", 1, 0, 8'd40, 16'd0, 1, 0, 1, 8'd33, 16'd0, 0, 1);
        step("bst4", 1, 0, 8'd40, 16'd0, 1, 0, 1, 8'd34, 16'd0, 1, 0);
        step("bst5", 1, 0, 8'd41, 16'd0, 1, 0, 0, 8'd34, 16'd0, 0, 1);
        idle("bst_flush");

        // D drops req mid-lock: C granted that cycle, next conflict to D
        step("drop0", 0, 0, 8'd0, 16'd0, 1, 0, 1, 8'd50, 16'd0, 0, 1);
        step("drop1", 1, 0, 8'd60, 16'd0, 1, 0, 1, 8'd51, 16'd0, 0, 1);
        step("drop2", 1, 0, 8'd60, 16'd0, 0, 0, 0, 8'd0, 16'd0, 1, 0);
        step("drop3", 1, 0, 8'd61, 16'd0, 1, 0, 0, 8'd52, 16'd0, 0, 1);
        step("drop4", 1, 0, 8'd61, 16'd0, 1, 0, 0, 8'd53, 16'd0, 1, 0);
        idle("drop_flush");

        // D write then C read of the same word
        step("wr_d", 0, 0, 8'd0, 16'd0, 1, 1, 0, 8'd3, 16'h00FF, 0, 1);
        step("rd_c", 1, 0, 8'd3, 16'd0, 0, 0, 0, 8'd0, 16'd0, 1, 0);
        idle("rd_c_ret");

        // Reset while a C read is in flight
        step("rst_rd", 1, 0, 8'd5, 16'd0, 0, 0, 0, 8'd0, 16'd0, 1, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid c_rvalid", 32'(c_rvalid), 32'd0);
        chk("rst_mid c_rdata", 32'(c_rdata), 32'd0);
        chk("rst_mid c_gnt", 32'(c_gnt), 32'd0);
        chk("rst_mid mem_rd_en", 32'(mem_rd_en), 32'd0);
        sb.delete();
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        @(negedge clk);
        c_req = 0;
        reset = 1'b0;
        step("post_rst", 1, 0, 8'd7, 16'd0, 0, 0, 0, 8'd0, 16'd0, 1, 0);
        idle("post_rst_ret");
        idle("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
